// File: rtl/snare_pkg.sv
// Shared types and constants for the snare voice controller.
package snare_pkg;

  localparam int FREQ_W_DEF   = 16;
  localparam int ENV_W_DEF    = 8;
  localparam int ACCENT_BOOST = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ATTACK = 2'd1,
    ST_DECAY  = 2'd2,
    ST_TAIL   = 2'd3
  } voice_state_t;

  // Accented hits decay the noise at half rate, never slower than 1 per tick.
  function automatic int noise_step_eff(input int step, input bit accent);
    int half;
    half = step >> 1;
    if (!accent) return step;
    return (half < 1) ? 1 : half;
  endfunction

endpackage

// File: rtl/snare_voice_ctrl_if.sv
// Trigger/tick inputs and oscillator/mixer control outputs of the snare voice.
// SNARE_ACCENT_EN adds the accent input.
interface snare_voice_ctrl_if
  import snare_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int ENV_W  = ENV_W_DEF
);
  logic              sample_tick;
  logic              trigger;
  logic [ENV_W-1:0]  velocity;
`ifdef SNARE_ACCENT_EN
  logic              accent;
`endif
  logic [FREQ_W-1:0] tri_freq;
  logic [ENV_W-1:0]  env_tone;
  logic [ENV_W-1:0]  env_noise;
  logic              en_sine;
  logic              en_triangle;
  logic              en_noise;
  logic              busy;
  logic              done;

  modport master (
`ifdef SNARE_ACCENT_EN
    output accent,
`endif
    output sample_tick, trigger, velocity,
    input  tri_freq, env_tone, env_noise, en_sine, en_triangle, en_noise, busy, done
  );

  modport slave (
`ifdef SNARE_ACCENT_EN
    input  accent,
`endif
    input  sample_tick, trigger, velocity,
    output tri_freq, env_tone, env_noise, en_sine, en_triangle, en_noise, busy, done
  );
endinterface

// File: rtl/snare_voice_ctrl_env_sat_step.sv
// Registered saturating step toward a limit; nxt/hit expose the value the next step would produce.
module env_sat_step #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] value,
  output logic [W-1:0] nxt,
  output logic         hit
);

  logic [W:0] sum;
  logic [W:0] floor_plus;

  // One extra bit so the add and the limit+step compare cannot wrap.
  always_comb begin
    sum        = {1'b0, value} + {1'b0, step};
    floor_plus = {1'b0, limit} + {1'b0, step};
    nxt        = limit;
    if (up) begin
      if (sum < {1'b0, limit}) nxt = sum[W-1:0];
    end else begin
      if ({1'b0, value} > floor_plus) nxt = value - step;
    end
    hit = (nxt == limit);
  end

  always_ff @(posedge clk) begin
    if (reset)     value <= RST_VAL;
    else if (load) value <= load_val;
    else if (en)   value <= nxt;
  end

endmodule

// File: rtl/snare_voice_ctrl.sv
// Envelope/sweep sequencer for the snare voice: IDLE->ATTACK->DECAY->TAIL, advancing on sample ticks.
// SNARE_ACCENT_EN adds an accent input that boosts the peak and slows the noise decay.
module snare_voice_ctrl
  import snare_pkg::*;
#(
  parameter int FREQ_W           = FREQ_W_DEF,
  parameter int ENV_W            = ENV_W_DEF,
  parameter int ATTACK_STEP      = 64,
  parameter int TONE_DECAY_STEP  = 4,
  parameter int NOISE_DECAY_STEP = 2,
  parameter int SWEEP_START      = 222,
  parameter int SWEEP_END        = 111,
  parameter int SWEEP_STEP       = 1
) (
  input  logic              main_clk,
  input  logic              reset,
  snare_voice_ctrl_if.slave bus
);

  voice_state_t     state;
  logic [ENV_W-1:0] peak;
  logic [ENV_W-1:0] vel_eff;
  logic [ENV_W-1:0] noise_step;
  logic             trig_ok;
  logic             adv;
  logic             sweeping;

  logic [ENV_W-1:0]  tone_val, tone_nxt, noise_val, noise_nxt;
  logic [FREQ_W-1:0] freq_val, freq_nxt;
  logic              tone_hit, noise_hit, freq_hit;
  logic              en_sine_q, en_tri_q, en_noise_q, busy_q, done_q;

`ifdef SNARE_ACCENT_EN
  logic             accent_q;
  logic [ENV_W:0]   boosted;

  always_comb begin
    boosted = {1'b0, bus.velocity} + (ENV_W+1)'(ACCENT_BOOST);
    vel_eff = bus.velocity;
    if (bus.accent) vel_eff = boosted[ENV_W] ? '1 : boosted[ENV_W-1:0];
  end

  assign noise_step = accent_q ? ENV_W'(noise_step_eff(NOISE_DECAY_STEP, 1'b1))
                               : ENV_W'(NOISE_DECAY_STEP);

  always_ff @(posedge main_clk) begin
    if (reset)        accent_q <= 1'b0;
    else if (trig_ok) accent_q <= bus.accent;
  end
`else
  assign vel_eff    = bus.velocity;
  assign noise_step = ENV_W'(NOISE_DECAY_STEP);
`endif

  // A zero peak cannot start a voice, but any hit restarts a running one.
  assign trig_ok  = bus.trigger && ((state != ST_IDLE) || (vel_eff != '0));
  assign adv      = bus.sample_tick && !trig_ok;
  assign sweeping = (state == ST_ATTACK) || (state == ST_DECAY);

  env_sat_step #(.W(ENV_W), .RST_VAL('0)) u_tone (
    .clk      (main_clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .en       (adv && sweeping),
    .up       (state == ST_ATTACK),
    .step     ((state == ST_ATTACK) ? ENV_W'(ATTACK_STEP) : ENV_W'(TONE_DECAY_STEP)),
    .limit    ((state == ST_ATTACK) ? peak : '0),
    .value    (tone_val),
    .nxt      (tone_nxt),
    .hit      (tone_hit)
  );

  // During ATTACK the noise envelope tracks the tone envelope exactly.
  env_sat_step #(.W(ENV_W), .RST_VAL('0)) u_noise (
    .clk      (main_clk),
    .reset    (reset),
    .load     (adv && (state == ST_ATTACK)),
    .load_val (tone_nxt),
    .en       (adv && ((state == ST_DECAY) || (state == ST_TAIL))),
    .up       (1'b0),
    .step     (noise_step),
    .limit    ('0),
    .value    (noise_val),
    .nxt      (noise_nxt),
    .hit      (noise_hit)
  );

  env_sat_step #(.W(FREQ_W), .RST_VAL(FREQ_W'(SWEEP_START))) u_sweep (
    .clk      (main_clk),
    .reset    (reset),
    .load     (trig_ok),
    .load_val (FREQ_W'(SWEEP_START)),
    .en       (adv && sweeping),
    .up       (1'b0),
    .step     (FREQ_W'(SWEEP_STEP)),
    .limit    (FREQ_W'(SWEEP_END)),
    .value    (freq_val),
    .nxt      (freq_nxt),
    .hit      (freq_hit)
  );

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      peak       <= '0;
      en_sine_q  <= 1'b0;
      en_tri_q   <= 1'b0;
      en_noise_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (trig_ok) begin
        state      <= ST_ATTACK;
        peak       <= vel_eff;
        en_sine_q  <= 1'b1;
        en_tri_q   <= 1'b1;
        en_noise_q <= 1'b1;
        busy_q     <= 1'b1;
      end else if (adv) begin
        case (state)
          ST_ATTACK: if (tone_hit) state <= ST_DECAY;
          ST_DECAY: begin
            if (tone_hit && noise_hit) begin
              state      <= ST_IDLE;
              en_sine_q  <= 1'b0;
              en_tri_q   <= 1'b0;
              en_noise_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else if (tone_hit) begin
              state     <= ST_TAIL;
              en_sine_q <= 1'b0;
              en_tri_q  <= 1'b0;
            end
          end
          ST_TAIL: begin
            if (noise_hit) begin
              state      <= ST_IDLE;
              en_noise_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tri_freq    = freq_val;
  assign bus.env_tone    = tone_val;
  assign bus.env_noise   = noise_val;
  assign bus.en_sine     = en_sine_q;
  assign bus.en_triangle = en_tri_q;
  assign bus.en_noise    = en_noise_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  logic unused_ok;
  assign unused_ok = ^{noise_nxt, freq_nxt, freq_hit};

endmodule

// File: tb/tb_snare_voice_ctrl.sv
// Directed bench for snare_voice_ctrl; a second instance with a low sweep start exercises the clamp.
module tb_snare_voice_ctrl;
  import snare_pkg::*;

  logic main_clk = 1'b0;
  logic reset    = 1'b1;
  int   tests    = 0;
  int   fails    = 0;

  always #5 main_clk = ~main_clk;

  snare_voice_ctrl_if #(.FREQ_W(16), .ENV_W(8)) bus ();
  snare_voice_ctrl_if #(.FREQ_W(16), .ENV_W(8)) bus_b ();

  assign bus_b.sample_tick = bus.sample_tick;
  assign bus_b.trigger     = bus.trigger;
  assign bus_b.velocity    = bus.velocity;
`ifdef SNARE_ACCENT_EN
  assign bus_b.accent      = bus.accent;
`endif

  snare_voice_ctrl u_dut (
    .main_clk (main_clk),
    .reset    (reset),
    .bus      (bus)
  );

  snare_voice_ctrl #(.SWEEP_START(114)) u_clamp (
    .main_clk (main_clk),
    .reset    (reset),
    .bus      (bus_b)
  );

  localparam logic [36:0] RST_OUTS = {16'd222, 8'd0, 8'd0, 5'b00000};

  // Drive one cycle of inputs, then settle just after the clock edge.
  task automatic step(input bit tk, input bit tg, input logic [7:0] v);
    bus.sample_tick = tk;
    bus.trigger     = tg;
    bus.velocity    = v;
    @(posedge main_clk);
    #1;
    bus.sample_tick = 1'b0;
    bus.trigger     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] outs;
    do_reset();
    outs = {bus.tri_freq, bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle,
            bus.en_noise, bus.busy, bus.done};
    tests++;
    if (outs !== RST_OUTS) begin
      fails++;
      $display("FAIL reset_outs got %h want %h", outs, RST_OUTS);
    end
  endtask

  task automatic test_idle_ticks();
    logic [36:0] outs;
    for (int i = 0; i < 5; i++) step(1, 0, 8'd0);
    outs = {bus.tri_freq, bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle,
            bus.en_noise, bus.busy, bus.done};
    tests++;
    if (outs !== RST_OUTS) begin
      fails++;
      $display("FAIL idle_ticks got %h want %h", outs, RST_OUTS);
    end
    step(0, 1, 8'd0);
    step(1, 0, 8'd0);
    outs = {bus.tri_freq, bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle,
            bus.en_noise, bus.busy, bus.done};
    tests++;
    if (outs !== RST_OUTS) begin
      fails++;
      $display("FAIL zero_peak_ignored got %h want %h", outs, RST_OUTS);
    end
  endtask

  task automatic test_full_run();
    logic [7:0] exp_att [4];
    exp_att = '{8'd64, 8'd128, 8'd192, 8'd255};
    do_reset();
    step(0, 1, 8'd255);
    tests++;
    if ({bus.busy, bus.en_sine, bus.en_triangle, bus.en_noise, bus.env_tone, bus.tri_freq}
        !== {4'b1111, 8'd0, 16'd222}) begin
      fails++;
      $display("FAIL trigger_start busy=%b en=%b%b%b tone=%0d freq=%0d want 1 111 0 222",
               bus.busy, bus.en_sine, bus.en_triangle, bus.en_noise, bus.env_tone, bus.tri_freq);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'd0);
      tests++;
      if ({bus.env_tone, bus.env_noise} !== {exp_att[i], exp_att[i]}) begin
        fails++;
        $display("FAIL attack[%0d] tone=%0d noise=%0d want %0d", i, bus.env_tone, bus.env_noise,
                 exp_att[i]);
      end
    end
    tests++;
    if (bus.tri_freq !== 16'd218) begin
      fails++;
      $display("FAIL sweep_4ticks got %0d want 218", bus.tri_freq);
    end
    tests++;
    if (bus_b.tri_freq !== 16'd111) begin
      fails++;
      $display("FAIL sweep_clamp got %0d want 111", bus_b.tri_freq);
    end
    for (int i = 0; i < 63; i++) step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise, bus.en_sine} !== {8'd3, 8'd129, 1'b1}) begin
      fails++;
      $display("FAIL decay_63 tone=%0d noise=%0d en_sine=%b want 3 129 1", bus.env_tone,
               bus.env_noise, bus.en_sine);
    end
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle, bus.en_noise, bus.busy}
        !== {8'd0, 8'd127, 4'b0011}) begin
      fails++;
      $display("FAIL enter_tail tone=%0d noise=%0d en=%b%b%b busy=%b want 0 127 001 1",
               bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle, bus.en_noise, bus.busy);
    end
    tests++;
    if (bus.tri_freq !== 16'd154) begin
      fails++;
      $display("FAIL sweep_at_tail got %0d want 154", bus.tri_freq);
    end
    for (int i = 0; i < 63; i++) step(1, 0, 8'd0);
    tests++;
    if ({bus.env_noise, bus.busy, bus.done, bus.tri_freq, bus_b.tri_freq}
        !== {8'd1, 2'b10, 16'd154, 16'd111}) begin
      fails++;
      $display("FAIL tail_63 noise=%0d busy=%b done=%b freq=%0d/%0d want 1 1 0 154/111",
               bus.env_noise, bus.busy, bus.done, bus.tri_freq, bus_b.tri_freq);
    end
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_noise, bus.en_noise, bus.busy, bus.done} !== {8'd0, 3'b001}) begin
      fails++;
      $display("FAIL end_voice noise=%0d en_noise=%b busy=%b done=%b want 0 0 0 1",
               bus.env_noise, bus.en_noise, bus.busy, bus.done);
    end
    step(0, 0, 8'd0);
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL done_one_cycle got %b want 0", bus.done);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    step(0, 1, 8'd204);
    for (int i = 0; i < 5; i++) step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise} !== {8'd200, 8'd202}) begin
      fails++;
      $display("FAIL pre_retrig tone=%0d noise=%0d want 200 202", bus.env_tone, bus.env_noise);
    end
    step(0, 1, 8'd100);
    tests++;
    if ({bus.env_tone, bus.tri_freq, bus.busy} !== {8'd200, 16'd222, 1'b1}) begin
      fails++;
      $display("FAIL retrig_load tone=%0d freq=%0d busy=%b want 200 222 1", bus.env_tone,
               bus.tri_freq, bus.busy);
    end
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise, bus.tri_freq} !== {8'd100, 8'd100, 16'd221}) begin
      fails++;
      $display("FAIL retrig_tick tone=%0d noise=%0d freq=%0d want 100 100 221", bus.env_tone,
               bus.env_noise, bus.tri_freq);
    end
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise, bus.en_sine} !== {8'd96, 8'd98, 1'b1}) begin
      fails++;
      $display("FAIL retrig_decay tone=%0d noise=%0d en_sine=%b want 96 98 1", bus.env_tone,
               bus.env_noise, bus.en_sine);
    end
  endtask

  task automatic test_trig_tick_reset();
    logic [36:0] outs;
    do_reset();
    step(1, 1, 8'd255);
    tests++;
    if ({bus.env_tone, bus.busy, bus.tri_freq} !== {8'd0, 1'b1, 16'd222}) begin
      fails++;
      $display("FAIL tick_dropped tone=%0d busy=%b freq=%0d want 0 1 222", bus.env_tone,
               bus.busy, bus.tri_freq);
    end
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.tri_freq} !== {8'd64, 16'd221}) begin
      fails++;
      $display("FAIL first_tick tone=%0d freq=%0d want 64 221", bus.env_tone, bus.tri_freq);
    end
    step(1, 0, 8'd0);
    reset = 1'b1;
    step(1, 1, 8'd255);
    reset = 1'b0;
    outs = {bus.tri_freq, bus.env_tone, bus.env_noise, bus.en_sine, bus.en_triangle,
            bus.en_noise, bus.busy, bus.done};
    tests++;
    if (outs !== RST_OUTS) begin
      fails++;
      $display("FAIL mid_attack_reset got %h want %h", outs, RST_OUTS);
    end
  endtask

`ifdef SNARE_ACCENT_EN
  task automatic test_accent();
    do_reset();
    bus.accent = 1'b1;
    step(0, 1, 8'd240);
    bus.accent = 1'b0;
    for (int i = 0; i < 4; i++) step(1, 0, 8'd0);
    tests++;
    if (bus.env_tone !== 8'd255) begin
      fails++;
      $display("FAIL accent_peak got %0d want 255", bus.env_tone);
    end
    step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    tests++;
    if ({bus.env_tone, bus.env_noise} !== {8'd247, 8'd253}) begin
      fails++;
      $display("FAIL accent_decay tone=%0d noise=%0d want 247 253", bus.env_tone, bus.env_noise);
    end
  endtask
`endif

  initial begin
    bus.sample_tick = 1'b0;
    bus.trigger     = 1'b0;
    bus.velocity    = 8'd0;
`ifdef SNARE_ACCENT_EN
    bus.accent      = 1'b0;
`endif
    test_reset();
    test_idle_ticks();
    test_full_run();
    test_retrigger();
    test_trig_tick_reset();
`ifdef SNARE_ACCENT_EN
    test_accent();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
